// File: rtl/dm_sync_if.sv
// rtl/dm_sync_if.sv - request/response bus bundle for the dm_sync data memory
interface dm_sync_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_width, req_sign, req_addr, req_wdata, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_sync.sv
// rtl/dm_sync.sv - single-outstanding word-array data memory with post-reset clear sweep
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_sync #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  dm_sync_if.slave    bus,
  output logic        clear_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_clear_busy;
  logic              w_accept;
  logic              w_fault;
  logic              w_store_commit;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_old_word;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load_val;
  logic [31:0]       w_lane_mask;
  logic [31:0]       w_wdata_lanes;
  logic [31:0]       w_merged;

  assign w_idx      = bus.req_addr[ADDR_W+1:2];
  assign w_old_word = r_mem[w_idx];
  assign w_shifted  = w_old_word >> {bus.req_addr[1:0], 3'b000};
  assign w_accept   = bus.req_valid && w_req_ready;
  assign w_store_commit = w_accept && bus.req_we && !w_fault;

  // Fault detection: illegal width, misalignment, or address beyond the array
  always_comb begin
    w_fault = 1'b0;
    if (bus.req_width == 2'b11) w_fault = 1'b1;
    if (bus.req_width == 2'b00 && bus.req_addr[1:0] != 2'b00) w_fault = 1'b1;
    if (bus.req_width == 2'b01 && bus.req_addr[0]) w_fault = 1'b1;
    if ((bus.req_addr >> (ADDR_W + 2)) != 32'd0) w_fault = 1'b1;
  end

  // Load lane extraction and sign/zero extension (half lanes are aligned when not faulting)
  always_comb begin
    w_load_val = 32'd0;
    case (bus.req_width)
      2'b00: w_load_val = w_old_word;
      2'b01: w_load_val = bus.req_sign ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                       : {16'd0, w_shifted[15:0]};
      2'b10: w_load_val = bus.req_sign ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                       : {24'd0, w_shifted[7:0]};
      default: w_load_val = 32'd0;
    endcase
  end

  // Store lane selection: replicate data across lanes, then mask in the addressed ones
  always_comb begin
    w_lane_mask   = 32'd0;
    w_wdata_lanes = bus.req_wdata;
    case (bus.req_width)
      2'b00: w_lane_mask = 32'hFFFF_FFFF;
      2'b01: begin
        w_lane_mask   = bus.req_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wdata_lanes = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_lane_mask   = 32'h0000_00FF << {bus.req_addr[1:0], 3'b000};
        w_wdata_lanes = {4{bus.req_wdata[7:0]}};
      end
      default: w_lane_mask = 32'd0;
    endcase
  end

  assign w_merged = (w_old_word & ~w_lane_mask) | (w_wdata_lanes & w_lane_mask);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_clear_busy = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear_busy = 1'b1;
        if (&r_clr_cnt) w_next_state = S_IDLE;
      end
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next_state = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_CLEAR;
    endcase
  end

  // Sweep counter and response capture at the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt   <= '0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_accept) begin
        r_rsp_err   <= w_fault;
        r_rsp_rdata <= (w_fault || bus.req_we) ? 32'd0 : w_load_val;
      end
    end
  end

  // Array writes: zero sweep after reset, then committed stores; contents never reset directly
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR)  r_mem[r_clr_cnt] <= 32'd0;
      else if (w_store_commit) r_mem[w_idx]     <= w_merged;
    end
  end

`ifdef DM_TRACE_EN
  // Trace each committed store with the full resulting word
  always_ff @(posedge clk) begin
    if (!reset && w_store_commit)
      $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, w_merged);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.req_pc;
`endif

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign clear_busy    = w_clear_busy;
endmodule

// File: tb/tb_dm_sync.sv
// tb/tb_dm_sync.sv - self-checking bench for dm_sync with a byte-level memory model
module tb_dm_sync;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_busy;

  dm_sync_if ifc ();

  dm_sync #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: byte-addressed memory, busy countdown, one pending response
  logic [7:0]  m_bytes [DEPTH*4];
  logic        m_live = 1'b0;
  int          m_clr_left = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;

  task automatic model_access(input logic we, input logic [1:0] w, input logic sg,
                              input logic [31:0] a, input logic [31:0] d);
    int nb;
    logic [31:0] v;
    nb = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
    m_err = (w == 2'd3) || ((a % nb) != 0) || (a >= 32'(DEPTH * 4));
    m_rdata = 32'd0;
    if (!m_err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) m_bytes[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = m_bytes[int'(a) + i];
        if (sg && nb < 4 && v[8*nb-1])
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        m_rdata = v;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_live = 1'b1;
      m_clr_left = DEPTH;
      m_pend = 1'b0;
      m_rdata = 32'd0;
      m_err = 1'b0;
      for (int i = 0; i < DEPTH*4; i++) m_bytes[i] = 8'h00;
    end else if (m_live) begin
      if (m_clr_left > 0) m_clr_left--;
      else if (m_pend) begin
        if (ifc.rsp_ready) m_pend = 1'b0;
      end else if (ifc.req_valid) begin
        model_access(ifc.req_we, ifc.req_width, ifc.req_sign, ifc.req_addr, ifc.req_wdata);
        m_pend = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("cmp_clear_busy", {31'd0, clear_busy}, {31'd0, m_clr_left > 0});
      check("cmp_req_ready", {31'd0, ifc.req_ready}, {31'd0, (m_clr_left == 0) && !m_pend});
      check("cmp_rsp_valid", {31'd0, ifc.rsp_valid}, {31'd0, m_pend});
      if (m_pend) begin
        check("cmp_rsp_rdata", ifc.rsp_rdata, m_rdata);
        check("cmp_rsp_err", {31'd0, ifc.rsp_err}, {31'd0, m_err});
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] w, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
    int n;
    ifc.req_we = we; ifc.req_width = w; ifc.req_sign = sg;
    ifc.req_addr = a; ifc.req_wdata = d; ifc.req_pc = 32'h1000 + a;
    ifc.rsp_ready = 1'b1; ifc.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ifc.req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    @(negedge clk);
    check("rsp_valid_after_accept", {31'd0, ifc.rsp_valid}, 32'd1);
    rd = ifc.rsp_rdata;
    er = ifc.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic count_clear(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (clear_busy && n < 100) begin n++; @(negedge clk); end
    check(nm, n, DEPTH);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
    string       nm;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] rd;
  logic er;
  logic [31:0] held;

  initial begin
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h3C, 32'h0,        32'h0,        1'b0, "load_after_clear"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h08, 32'h12345678, 32'h0,        1'b0, "store_word_8"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0B, 32'h0,        32'h00000012, 1'b0, "load_byte_B_zx"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0B, 32'hFFFFFF80, 32'h0,        1'b0, "store_byte_B"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        32'hFFFF8034, 1'b0, "load_half_A_sx"});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 32'h0B, 32'h0,        32'hFFFFFF80, 1'b0, "load_byte_B_sx"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        32'h00005678, 1'b0, "load_half_8_zx"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h04, 32'h11223344, 32'h0,        1'b0, "store_word_4"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h05, 32'h000000AB, 32'h0,        1'b0, "store_byte_5"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h04, 32'h0,        32'h1122AB44, 1'b0, "load_word_4"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        32'h0,        1'b1, "fault_half_3"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h02, 32'hFFFFFFFF, 32'h0,        1'b1, "fault_word_st_2"});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h0,        1'b1, "fault_width_11"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h10000, 32'h0,     32'h0,        1'b1, "fault_addr_10000"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h40, 32'h000000EE, 32'h0,        1'b1, "fault_addr_40"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h00, 32'h0,        32'h0,        1'b0, "word0_unchanged"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h04, 32'h0,        32'h1122AB44, 1'b0, "word4_unchanged"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h3C, 32'h0,        32'h0,        1'b0, "word3C_unchanged"});

    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_width = 2'd0; ifc.req_sign = 1'b0;
    ifc.req_addr = 32'd0; ifc.req_wdata = 32'd0; ifc.req_pc = 32'd0; ifc.rsp_ready = 1'b1;

    #2 reset = 1'b1;
    #1;
    check("rst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, ifc.req_ready}, 32'd0);
    check("rst_clear_busy", {31'd0, clear_busy}, 32'd1);
    check("rst_rsp_rdata", ifc.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, ifc.rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    count_clear("clear_len_initial");

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].w, vecs[i].sg, vecs[i].a, vecs[i].d, rd, er);
      check({vecs[i].nm, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].nm, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_er});
    end

    // Stalled response: hold rsp_ready low and confirm outputs stay put
    ifc.req_we = 1'b0; ifc.req_width = 2'd0; ifc.req_sign = 1'b0; ifc.req_addr = 32'h08;
    ifc.rsp_ready = 1'b0; ifc.req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    @(negedge clk);
    held = ifc.rsp_rdata;
    check("stall_first_rdata", held, 32'h80345678);
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd1);
      check("stall_rsp_rdata", ifc.rsp_rdata, held);
      check("stall_req_ready", {31'd0, ifc.req_ready}, 32'd0);
      @(negedge clk);
    end

    // Reset during the stall drops the response at once and restarts the sweep
    #1 reset = 1'b1;
    #1;
    check("midrsp_rst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    check("midrsp_rst_clear_busy", {31'd0, clear_busy}, 32'd1);
    check("midrsp_rst_rsp_rdata", ifc.rsp_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ifc.rsp_ready = 1'b1;
    count_clear("clear_len_after_stall_reset");

    do_req(1'b0, 2'd0, 1'b0, 32'h08, 32'h0, rd, er);
    check("post_sweep_word8", rd, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h04, 32'h0, rd, er);
    check("post_sweep_word4", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end
endmodule
